// File: rtl/bin_stream_pack.sv
// Packs camera raster timing (vsync/href/pixel strobe) carrying a 1-bit pixel into sop/eop framed packets.
// Optional frame counter output enabled by defining BIN_STREAM_PACK_FCNT_EN.
module bin_stream_pack #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic        cam_pvld,
    input  logic        cam_pix,
    output logic        dout,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_vld,
`ifdef BIN_STREAM_PACK_FCNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic        frame_err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [RW-1:0] row, row_nxt;
    logic          vs_q, href_q;
    logic          vs_act, vsync_start, accept, short_line;
    logic          dout_nxt, sop_nxt, eop_nxt, vld_nxt, err_nxt;

    assign vs_act      = (cam_vsync == VSYNC_POL);
    assign vsync_start = vs_act & ~vs_q;
    assign accept      = cam_href & cam_pvld;
    assign short_line  = href_q & ~cam_href & (col != '0);

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        dout_nxt  = 1'b0;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (vsync_start) begin
                    state_nxt = ARMED;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end
            end
            ARMED: begin
                col_nxt = '0;
                row_nxt = '0;
                // A pixel coinciding with a new vsync edge is dropped; vsync wins.
                if (!vsync_start && accept) begin
                    vld_nxt   = 1'b1;
                    dout_nxt  = cam_pix;
                    sop_nxt   = 1'b1;
                    col_nxt   = CW'(1);
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vsync_start) begin
                    err_nxt   = 1'b1;
                    state_nxt = ARMED;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end else if (short_line) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end else if (accept) begin
                    vld_nxt  = 1'b1;
                    dout_nxt = cam_pix;
                    if (col == COL_LAST) begin
                        col_nxt = '0;
                        if (row == ROW_LAST) begin
                            eop_nxt   = 1'b1;
                            row_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            row_nxt = row + 1'b1;
                        end
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // vs_q resets to "active" so a vsync already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            vs_q      <= 1'b1;
            href_q    <= 1'b0;
            dout      <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            dout_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            vs_q      <= vs_act;
            href_q    <= cam_href;
            dout      <= dout_nxt;
            dout_sop  <= sop_nxt;
            dout_eop  <= eop_nxt;
            dout_vld  <= vld_nxt;
            frame_err <= err_nxt;
        end
    end

`ifdef BIN_STREAM_PACK_FCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (eop_nxt)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bin_stream_pack.sv
// Scoreboard bench for bin_stream_pack at IMG_W=4, IMG_H=3.
module tb_bin_stream_pack;

    logic clk = 1'b0;
    logic rst_n, cam_vsync, cam_href, cam_pvld, cam_pix;
    logic dout, dout_sop, dout_eop, dout_vld, frame_err;
`ifdef BIN_STREAM_PACK_FCNT_EN
    logic [15:0] frame_cnt;
`endif

    bin_stream_pack #(.IMG_W(4), .IMG_H(3), .VSYNC_POL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_pvld  (cam_pvld),
        .cam_pix   (cam_pix),
        .dout      (dout),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop),
        .dout_vld  (dout_vld),
`ifdef BIN_STREAM_PACK_FCNT_EN
        .frame_cnt (frame_cnt),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] flags;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   err_seen = 0;
    int   err_exp = 0;
    int   good_frames = 0;
    logic err_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output pixel, checks flags and latency.
    always @(negedge clk) begin
        if (dout_vld) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_vld got={pix,sop,eop}=%b want=none", {dout, dout_sop, dout_eop});
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pix_flags", int'({dout, dout_sop, dout_eop}), int'(e.flags));
                check("pix_latency", cyc, e.cyc);
            end
        end else if (dout_sop || dout_eop) begin
            checks++;
            failures++;
            $display("FAIL sop_eop_without_vld got sop=%0b eop=%0b want 0", dout_sop, dout_eop);
        end
        if (frame_err) begin
            err_seen++;
            check("err_one_cycle", int'(err_prev), 0);
        end
        err_prev = frame_err;
    end

    task automatic drive(input logic vs, input logic hr, input logic pv, input logic px);
        cam_vsync = vs;
        cam_href  = hr;
        cam_pvld  = pv;
        cam_pix   = px;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic px, input logic s, input logic e);
        exp_t t;
        t.flags = {px, s, e};
        t.cyc   = cyc + 1;
        q.push_back(t);
    endtask

    task automatic vsync_pulse();
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic send_frame(input logic [11:0] pat, input bit gaps);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                int idx;
                idx = r * 4 + c;
                push(pat[idx], idx == 0, idx == 11);
                drive(0, 1, 1, pat[idx]);
                if (gaps) drive(0, 1, 0, 1);
            end
            drive(0, 0, 0, 0);
            drive(0, 0, 0, 0);
        end
        good_frames++;
    endtask

    task automatic settle_and_check(input string nm);
        repeat (4) drive(0, 0, 0, 0);
        check({nm, "_queue_empty"}, q.size(), 0);
        check({nm, "_err_count"}, err_seen, err_exp);
    endtask

    initial begin
        rst_n = 1'b0;
        cam_vsync = 0; cam_href = 0; cam_pvld = 0; cam_pix = 0;
        @(negedge clk);
        check("rst_vld", int'(dout_vld), 0);
        check("rst_sop", int'(dout_sop), 0);
        check("rst_eop", int'(dout_eop), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_dout", int'(dout), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Pixels before any vsync edge are ignored.
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 1);
        drive(0, 0, 0, 0);

        // Basic frame, then a trailing line after eop that must be dropped.
        vsync_pulse();
        send_frame(12'hA5C, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 1);
        settle_and_check("basic");

        // Same frame shape with pixel-strobe gaps.
        vsync_pulse();
        send_frame(12'h3C9, 1);
        settle_and_check("gaps");

        // Short second line: error, no eop; trailing pixels dropped; next frame clean.
        vsync_pulse();
        push(1, 1, 0); drive(0, 1, 1, 1);
        push(0, 0, 0); drive(0, 1, 1, 0);
        push(1, 0, 0); drive(0, 1, 1, 1);
        push(1, 0, 0); drive(0, 1, 1, 1);
        drive(0, 0, 0, 0);
        push(0, 0, 0); drive(0, 1, 1, 0);
        push(1, 0, 0); drive(0, 1, 1, 1);
        drive(0, 0, 0, 0);
        err_exp++;
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 1);
        drive(0, 0, 0, 0);
        vsync_pulse();
        send_frame(12'hF0F, 0);
        settle_and_check("short_line");

        // vsync edge after 7 pixels: error, re-armed, next 12 pixels form a fresh frame.
        vsync_pulse();
        for (int c = 0; c < 4; c++) begin
            push(c[0], c == 0, 0);
            drive(0, 1, 1, c[0]);
        end
        drive(0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            push(~c[0], 0, 0);
            drive(0, 1, 1, ~c[0]);
        end
        drive(1, 1, 0, 0);
        err_exp++;
        drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        send_frame(12'h6B2, 0);
        settle_and_check("vsync_mid");

        // vsync edge coincident with an accepted pixel while armed: pixel dropped, no error.
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 1, 1, 1);
        drive(0, 0, 0, 0);
        send_frame(12'h81E, 0);
        settle_and_check("vsync_coincident");

        // Reset during pixel 5; vsync active across release must not start a frame.
        vsync_pulse();
        for (int c = 0; c < 4; c++) begin
            push(c[0], c == 0, 0);
            drive(0, 1, 1, c[0]);
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        #1;
        cam_href = 1; cam_pvld = 1; cam_pix = 1;
        rst_n = 1'b0;
        good_frames = 0;
        @(negedge clk);
        check("midrst_vld", int'(dout_vld), 0);
        check("midrst_dout", int'(dout), 0);
        check("midrst_err", int'(frame_err), 0);
        cam_vsync = 1;
        @(posedge clk);
        #1;
        drive(1, 1, 1, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 1);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 1);
        drive(0, 0, 0, 0);
        settle_and_check("reset_hold");
        vsync_pulse();
        send_frame(12'h5A5, 0);
        settle_and_check("after_reset");

`ifdef BIN_STREAM_PACK_FCNT_EN
        // Two more good frames plus one aborted frame.
        vsync_pulse();
        send_frame(12'h123, 0);
        vsync_pulse();
        send_frame(12'hFED, 0);
        vsync_pulse();
        push(1, 1, 0); drive(0, 1, 1, 1);
        push(0, 0, 0); drive(0, 1, 1, 0);
        drive(0, 0, 0, 0);
        err_exp++;
        settle_and_check("fcnt");
        check("frame_cnt", int'(frame_cnt), good_frames);
        check("frame_cnt_is_3", good_frames, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
